// File: rtl/ad9826_serial_port_pkg.sv
// Shared register map and frame helpers for the AD9826 3-wire serial port.
// The frame layout is {rw, addr[2:0], 3'b000, data[8:0]}, sent MSB first.
package ad9826_serial_port_pkg;

    localparam logic [2:0] AD_REG_CONFIG = 3'd0;
    localparam logic [2:0] AD_REG_MUX    = 3'd1;
    localparam logic [2:0] AD_REG_PGA_R  = 3'd2;
    localparam logic [2:0] AD_REG_PGA_G  = 3'd3;
    localparam logic [2:0] AD_REG_PGA_B  = 3'd4;
    localparam logic [2:0] AD_REG_OFS_R  = 3'd5;
    localparam logic [2:0] AD_REG_OFS_G  = 3'd6;
    localparam logic [2:0] AD_REG_OFS_B  = 3'd7;

    localparam logic AD_RW_WRITE = 1'b0;
    localparam logic AD_RW_READ  = 1'b1;

    // Read frames carry zeros in the data field; the device drives those slots.
    function automatic logic [15:0] ad_frame(input logic rw, input logic [2:0] addr,
                                             input logic [8:0] data);
        return {rw, addr, 3'b000, (rw == AD_RW_READ) ? 9'd0 : data};
    endfunction

endpackage

// File: rtl/ad9826_half_tick.sv
// Reloadable down-counter: tick_o is high while the count is zero, then the
// counter reloads from load_i. restart_i forces a reload at any time.
module ad9826_half_tick #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] load_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (restart_i || cnt_q == '0) begin
            cnt_d = load_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/ad9826_serial_port.sv
// AD9826 serial-port master: turns one register command into a 16-bit
// SLOAD/SCLK/SDATA frame and returns the 9-bit contents on read frames.
module ad9826_serial_port
    import ad9826_serial_port_pkg::*;
#(
    parameter int HALF_DIV = 5,
    parameter int GAP_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [2:0] cmd_addr,
    input  logic [8:0] cmd_data,
    output logic       rd_valid,
    output logic [8:0] rd_data,
    output logic       busy,
    output logic       ad_sload,
    output logic       ad_sclk,
    output logic       ad_sdata_o,
    output logic       ad_sdata_oe,
    input  logic       ad_sdata_i
);

    localparam int CNT_W = $clog2(HALF_DIV * GAP_DIV);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(HALF_DIV * GAP_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] frame_q, frame_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic        rw_q, rw_d;
    logic [8:0]  rdsh_q, rdsh_d;
    logic [8:0]  rddata_q, rddata_d;
    logic        sload_q, sload_d;
    logic        sclk_q, sclk_d;
    logic        sdata_q, sdata_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        rdv_q, rdv_d;
    logic        ready_q, ready_d;
    logic        accept;
    logic        tick;
    logic [CNT_W-1:0] cnt_load;

    assign accept   = (state_q == S_IDLE) && cmd_valid;
    assign cnt_load = (state_d == S_GAP) ? GAP_LOAD : HALF_LOAD;

    ad9826_half_tick #(.CNT_W(CNT_W)) u_half_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (accept),
        .load_i    (cnt_load),
        .tick_o    (tick)
    );

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        bitcnt_d = bitcnt_q;
        rw_d     = rw_q;
        rdsh_d   = rdsh_q;
        rddata_d = rddata_q;
        sload_d  = sload_q;
        sclk_d   = sclk_q;
        sdata_d  = sdata_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        rdv_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    frame_d  = ad_frame(cmd_rw, cmd_addr, cmd_data);
                    rw_d     = cmd_rw;
                    bitcnt_d = 4'd15;
                    state_d  = S_SETUP;
                    sload_d  = 1'b0;
                    sclk_d   = 1'b0;
                    sdata_d  = cmd_rw;
                    oe_d     = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bitcnt_q == 4'd0) begin
                            state_d = S_HOLD;
                        end else begin
                            bitcnt_d = bitcnt_q - 4'd1;
                            sdata_d  = frame_q[bitcnt_q - 4'd1];
                            // Hand SDATA to the device once the read header is out.
                            if (rw_q == AD_RW_READ && bitcnt_q <= 4'd9) begin
                                oe_d    = 1'b0;
                                sdata_d = 1'b0;
                            end
                        end
                    end else begin
                        sclk_d = 1'b1;
                        if (rw_q == AD_RW_READ && bitcnt_q <= 4'd8) begin
                            rdsh_d = {rdsh_q[7:0], ad_sdata_i};
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    state_d = S_GAP;
                    sload_d = 1'b1;
                    oe_d    = 1'b0;
                    sdata_d = 1'b0;
                    if (rw_q == AD_RW_READ) begin
                        rdv_d    = 1'b1;
                        rddata_d = rdsh_q;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            bitcnt_q <= '0;
            rw_q     <= 1'b0;
            rdsh_q   <= '0;
            rddata_q <= '0;
            sload_q  <= 1'b1;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            rdv_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            bitcnt_q <= bitcnt_d;
            rw_q     <= rw_d;
            rdsh_q   <= rdsh_d;
            rddata_q <= rddata_d;
            sload_q  <= sload_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            rdv_q    <= rdv_d;
            ready_q  <= ready_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign rd_valid    = rdv_q;
    assign rd_data     = rddata_q;
    assign busy        = busy_q;
    assign ad_sload    = sload_q;
    assign ad_sclk     = sclk_q;
    assign ad_sdata_o  = sdata_q;
    assign ad_sdata_oe = oe_q;

endmodule

// File: tb/tb_ad9826_serial_port.sv
// Scoreboard bench for ad9826_serial_port: stimulus queues expected frames,
// a pin monitor decodes each SLOAD-low window and compares against them.
module tb_ad9826_serial_port;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [8:0] cmd_data = '0;
    logic       rd_valid;
    logic [8:0] rd_data;
    logic       busy;
    logic       ad_sload;
    logic       ad_sclk;
    logic       ad_sdata_o;
    logic       ad_sdata_oe;
    logic       ad_sdata_i = 1'b0;

    ad9826_serial_port #(.HALF_DIV(5), .GAP_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .ad_sload    (ad_sload),
        .ad_sclk     (ad_sclk),
        .ad_sdata_o  (ad_sdata_o),
        .ad_sdata_oe (ad_sdata_oe),
        .ad_sdata_i  (ad_sdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        bit          is_read;
        int          gap;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] rd_q[$];
    int checks = 0;
    int errors = 0;
    int frames_seen = 0;
    int rdv_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic expect_frame(input logic [15:0] word, input bit is_read, input int gap,
                                input logic [8:0] rd_val);
        exp_t e;
        e.word = word;
        e.is_read = is_read;
        e.gap = gap;
        exp_q.push_back(e);
        if (is_read) rd_q.push_back(rd_val);
    endtask

    // ---------------- pin monitor ----------------
    logic        p_sload = 1'b1;
    logic        p_sclk = 1'b0;
    bit          in_frame = 0;
    logic [15:0] cap;
    int nrise, lowcnt, oe_drop, first_rise, last_rise, fall_gap;
    int cyc = 0;
    int rise_cyc = -1000;
    bit ready_hi;

    task automatic frame_end();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got word %0h expected no frame", cap);
        end else begin
            e = exp_q.pop_front();
            frames_seen++;
            $display("frame %0d: captured %04h", frames_seen, cap);
            check("sload_low_cycles", lowcnt, 165);
            check("sclk_pulses", nrise, 16);
            check("sclk_rise_span", last_rise - first_rise, 150);
            check("ready_low_in_frame", {31'd0, ready_hi}, 0);
            if (e.is_read) begin
                check("read_header_bits", {25'd0, cap[15:9]}, {25'd0, e.word[15:9]});
                check("oe_drop_after_rise", oe_drop, 7);
            end else begin
                check("write_word", {16'd0, cap}, {16'd0, e.word});
                check("oe_whole_frame", oe_drop, -1);
            end
            if (e.gap >= 0) check("b2b_sload_gap", fall_gap, e.gap);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] rexp;
        cyc++;
        if (rst) begin
            in_frame = 0;
        end else begin
            if (p_sload && !ad_sload) begin
                in_frame = 1;
                cap = '0;
                nrise = 0;
                lowcnt = 0;
                oe_drop = -1;
                first_rise = 0;
                last_rise = 0;
                ready_hi = 0;
                fall_gap = cyc - rise_cyc;
            end
            if (in_frame && !ad_sload) begin
                lowcnt++;
                if (cmd_ready) ready_hi = 1;
                if (ad_sclk && !p_sclk) begin
                    nrise++;
                    cap = {cap[14:0], ad_sdata_o};
                    if (nrise == 1) first_rise = cyc;
                    last_rise = cyc;
                end
                if (!ad_sdata_oe && oe_drop < 0) oe_drop = nrise;
            end
            if (!p_sload && ad_sload) begin
                rise_cyc = cyc;
                if (in_frame) begin
                    in_frame = 0;
                    frame_end();
                end
            end
            if (rd_valid) begin
                rdv_seen++;
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd_valid: got rd_data %0h expected no strobe", rd_data);
                end else begin
                    rexp = rd_q.pop_front();
                    check("rd_data", {23'd0, rd_data}, {23'd0, rexp});
                end
            end
        end
        p_sload = ad_sload;
        p_sclk = ad_sclk;
    end

    // ---------------- AD9826 read-data model ----------------
    logic [8:0] dev_val = 9'h1A5;
    logic d_psload = 1'b1;
    logic d_psclk = 1'b0;
    int d_nr = 0;

    always @(negedge clk) begin
        if (!ad_sload && d_psload) d_nr = 0;
        if (!ad_sload) begin
            if (ad_sclk && !d_psclk) d_nr++;
            if (!ad_sclk && d_psclk && d_nr >= 7 && d_nr <= 15) ad_sdata_i = dev_val[15 - d_nr];
        end else begin
            ad_sdata_i = 1'b0;
        end
        d_psload = ad_sload;
        d_psclk = ad_sclk;
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic rw, input logic [2:0] a, input logic [8:0] d, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw = rw;
        cmd_addr = a;
        cmd_data = d;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 1000 cycles");
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || !cmd_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy || !cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%0b expected busy=0 within 2000 cycles", busy);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_sload"}, {31'd0, ad_sload}, 1);
        check({tag, "_sclk"}, {31'd0, ad_sclk}, 0);
        check({tag, "_sdata_o"}, {31'd0, ad_sdata_o}, 0);
        check({tag, "_oe"}, {31'd0, ad_sdata_oe}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 0);
        check({tag, "_rd_data"}, {23'd0, rd_data}, 0);
    endtask

    initial begin
        int r, n;
        logic ps;

        #2 rst = 1'b1;
        #1 check_reset_pins("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("ready_after_reset", {31'd0, cmd_ready}, 1);

        // 1: config write
        expect_frame(16'h00D8, 0, -1, 9'h0);
        issue(1'b0, 3'd0, 9'h0D8, 0);
        wait_idle();

        // 2: mux write
        expect_frame(16'h10C0, 0, -1, 9'h0);
        issue(1'b0, 3'd1, 9'h0C0, 0);
        wait_idle();

        // 3: read of offset-red; data field on the command is ignored
        expect_frame(16'hD000, 1, -1, 9'h1A5);
        issue(1'b1, 3'd5, 9'h0FF, 0);
        wait_idle();

        // 4: two writes with cmd_valid held across both
        expect_frame(16'h2155, 0, -1, 9'h0);
        expect_frame(16'h70AA, 0, 11, 9'h0);
        issue(1'b0, 3'd2, 9'h155, 1);
        issue(1'b0, 3'd7, 9'h0AA, 0);
        wait_idle();

        // 5: reset during the 6th SCLK pulse, then a clean write
        issue(1'b0, 3'd6, 9'h111, 0);
        r = 0;
        n = 0;
        ps = ad_sclk;
        while (r < 6 && n < 1000) begin
            @(negedge clk);
            n++;
            if (ad_sclk && !ps) r++;
            ps = ad_sclk;
        end
        check("reach_6th_sclk", r, 6);
        #2 rst = 1'b1;
        #1 check_reset_pins("midframe_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("ready_after_midframe_reset", {31'd0, cmd_ready}, 1);
        expect_frame(16'h31FF, 0, -1, 9'h0);
        issue(1'b0, 3'd3, 9'h1FF, 0);
        wait_idle();

        // 6: a cmd_valid pulse during a frame must be ignored
        expect_frame(16'h403C, 0, -1, 9'h0);
        issue(1'b0, 3'd4, 9'h03C, 0);
        repeat (20) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw = 1'b0;
        cmd_addr = 3'd6;
        cmd_data = 9'h000;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        repeat (250) @(negedge clk);

        check("exp_queue_empty", exp_q.size(), 0);
        check("rd_queue_empty", rd_q.size(), 0);
        check("frames_seen", frames_seen, 7);
        check("rd_valid_pulses", rdv_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
